// File: rtl/capture_sequencer_if.sv
// Handshake between the capture sequencer (master) and the byte-capture datapath (slave).
interface capture_sequencer_if #(
  parameter int AW = 3
);
  logic          loaddata;
  logic [AW-1:0] wr_addr;
  logic          calc_start;
  logic          inputdata_ready;
  logic          calc_done;

  modport master (
    output loaddata,
    output wr_addr,
    output calc_start,
    input  inputdata_ready,
    input  calc_done
  );

  modport slave (
    input  loaddata,
    input  wr_addr,
    input  calc_start,
    output inputdata_ready,
    output calc_done
  );
endinterface

// File: rtl/capture_sequencer.sv
// Capture sequencer: debounced operator presses drive byte loads, then a datapath calculation and result display.
// Optional LOAD timeout with sticky error is enabled by defining SEQ_TIMEOUT_EN.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | waiting for the first press of a frame
// LOAD       | loaddata high, waiting for inputdata_ready at wr_addr
// WAIT_REL   | byte captured, wr_addr advanced, waiting for the next press
// CALC       | one-cycle calc_start pulse
// WAIT_DONE  | waiting for calc_done
// SHOW       | result on display until the next press
// ERROR      | LOAD timed out; left only through reset (SEQ_TIMEOUT_EN)
module capture_sequencer #(
  parameter int DEPTH      = 8,
  parameter int AW         = 3,
  parameter int DEB_CYCLES = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enter,
  capture_sequencer_if.master dp,
  output logic                busy,
  output logic                show,
  output logic [3:0]          frame_cnt,
  output logic                err
);

  localparam int            DW        = $clog2(DEB_CYCLES + 1);
  localparam logic [DW-1:0] DEB_MAX   = DW'(DEB_CYCLES);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);

`ifdef SEQ_TIMEOUT_EN
  localparam int            TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WAIT_REL, S_CALC, S_WAIT_DONE, S_SHOW, S_ERROR
  } state_t;

  logic [TW-1:0] tmr;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WAIT_REL, S_CALC, S_WAIT_DONE, S_SHOW
  } state_t;
`endif

  state_t        state;
  logic          enter_m;
  logic          enter_s;
  logic [DW-1:0] deb_cnt;
  logic          press;

  // press fires once when the count reaches DEB_CYCLES; the saturated count blocks repeats until release
  always_ff @(posedge clk) begin
    if (reset) begin
      enter_m <= 1'b0;
      enter_s <= 1'b0;
      deb_cnt <= '0;
      press   <= 1'b0;
    end else begin
      enter_m <= enter;
      enter_s <= enter_m;
      press   <= enter_s && (deb_cnt == DEB_LAST);
      if (!enter_s)
        deb_cnt <= '0;
      else if (deb_cnt != DEB_MAX)
        deb_cnt <= deb_cnt + 1'b1;
    end
  end

  // A press can only arrive after enter_s has dropped since the previous one,
  // so WAIT_REL accepting any press is the same as waiting for release first.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      dp.loaddata   <= 1'b0;
      dp.wr_addr    <= '0;
      dp.calc_start <= 1'b0;
      busy          <= 1'b0;
      show          <= 1'b0;
      frame_cnt     <= 4'd0;
`ifdef SEQ_TIMEOUT_EN
      err           <= 1'b0;
      tmr           <= '0;
`endif
    end else begin
      dp.calc_start <= 1'b0;
      unique case (state)
        S_IDLE, S_WAIT_REL: begin
          if (press) begin
            state       <= S_LOAD;
            dp.loaddata <= 1'b1;
            busy        <= 1'b1;
`ifdef SEQ_TIMEOUT_EN
            tmr         <= TMR_LOAD;
`endif
          end
        end
        S_LOAD: begin
          if (dp.inputdata_ready) begin
            dp.loaddata <= 1'b0;
            if (dp.wr_addr == ADDR_LAST) begin
              state         <= S_CALC;
              dp.calc_start <= 1'b1;
            end else begin
              state      <= S_WAIT_REL;
              dp.wr_addr <= dp.wr_addr + 1'b1;
            end
          end
`ifdef SEQ_TIMEOUT_EN
          else if (tmr == '0) begin
            state       <= S_ERROR;
            dp.loaddata <= 1'b0;
            err         <= 1'b1;
          end else begin
            tmr <= tmr - 1'b1;
          end
`endif
        end
        S_CALC: begin
          state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (dp.calc_done) begin
            state     <= S_SHOW;
            show      <= 1'b1;
            frame_cnt <= frame_cnt + 4'd1;
          end
        end
        S_SHOW: begin
          if (press) begin
            state      <= S_IDLE;
            show       <= 1'b0;
            busy       <= 1'b0;
            dp.wr_addr <= '0;
          end
        end
`ifdef SEQ_TIMEOUT_EN
        S_ERROR: begin
          state <= S_ERROR;
        end
`endif
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifndef SEQ_TIMEOUT_EN
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_capture_sequencer.sv
// Self-checking bench for capture_sequencer: directed scenarios plus randomized traffic against a phase-level model.
module tb_capture_sequencer;
  localparam int DEPTH   = 8;
  localparam int AW      = 3;
  localparam int DEB     = 4;
  localparam int TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enter = 1'b0;
  logic       ready = 1'b0;
  logic       done = 1'b0;
  logic       busy, show, err;
  logic [3:0] frame_cnt;

  int checks = 0;
  int errors = 0;
  int ld_rise = 0;
  logic ld_prev = 1'b0;

  capture_sequencer_if #(.AW(AW)) dp_if ();
  assign dp_if.inputdata_ready = ready;
  assign dp_if.calc_done       = done;

  capture_sequencer #(
    .DEPTH(DEPTH), .AW(AW), .DEB_CYCLES(DEB), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .enter(enter), .dp(dp_if),
    .busy(busy), .show(show), .frame_cnt(frame_cnt), .err(err)
  );

  always #5 clk = ~clk;

  // Reference model: phase named by string, enter run-length as plain integer
  string m_phase = "IDLE";
  int    m_addr = 0, m_frames = 0, m_run = 0, m_wait = 0;
  bit    m_m = 0, m_s = 0, m_press = 0, p_now, es_now;

  always @(posedge clk) begin
    if (reset) begin
      m_phase = "IDLE"; m_addr = 0; m_frames = 0; m_run = 0; m_wait = 0;
      m_m = 0; m_s = 0; m_press = 0;
    end else begin
      p_now   = m_press;
      es_now  = m_s;
      m_press = es_now && (m_run + 1 == DEB);
      m_run   = es_now ? m_run + 1 : 0;
      m_s     = m_m;
      m_m     = enter;
      if (m_phase == "IDLE" || m_phase == "WAIT_REL") begin
        if (p_now) begin m_phase = "LOAD"; m_wait = 0; end
      end else if (m_phase == "LOAD") begin
        if (ready) begin
          if (m_addr == DEPTH - 1) m_phase = "CALC";
          else begin m_addr = m_addr + 1; m_phase = "WAIT_REL"; end
        end else begin
          m_wait = m_wait + 1;
`ifdef SEQ_TIMEOUT_EN
          if (m_wait == TIMEOUT) m_phase = "ERROR";
`endif
        end
      end else if (m_phase == "CALC") begin
        m_phase = "WAIT_DONE";
      end else if (m_phase == "WAIT_DONE") begin
        if (done) begin m_phase = "SHOW"; m_frames = m_frames + 1; end
      end else if (m_phase == "SHOW") begin
        if (p_now) begin m_phase = "IDLE"; m_addr = 0; end
      end
    end
  end

  always @(negedge clk) begin
    logic e_ld, e_cs, e_busy, e_show, e_err;
    logic [3:0] e_fc;
    e_ld   = (m_phase == "LOAD");
    e_cs   = (m_phase == "CALC");
    e_busy = (m_phase != "IDLE");
    e_show = (m_phase == "SHOW");
    e_err  = (m_phase == "ERROR");
    e_fc   = 4'(m_frames % 16);
    checks++;
    if (dp_if.loaddata !== e_ld || dp_if.calc_start !== e_cs || busy !== e_busy ||
        show !== e_show || err !== e_err || frame_cnt !== e_fc || int'(dp_if.wr_addr) != m_addr) begin
      errors++;
      $display("FAIL cycle_model t=%0t phase=%s got ld=%b cs=%b busy=%b show=%b err=%b fc=%0d addr=%0d exp ld=%b cs=%b busy=%b show=%b err=%b fc=%0d addr=%0d",
               $time, m_phase, dp_if.loaddata, dp_if.calc_start, busy, show, err, frame_cnt, dp_if.wr_addr,
               e_ld, e_cs, e_busy, e_show, e_err, e_fc, m_addr);
    end
    if (dp_if.loaddata && !ld_prev) ld_rise++;
    ld_prev = dp_if.loaddata;
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_load(output int lat);
    lat = 0;
    while (dp_if.loaddata !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("load_seen", int'(dp_if.loaddata), 1);
  endtask

  task automatic load_byte(input int exp_addr, input int hold, input bit last, input bit inject,
                           output int lat);
    int spent;
    enter = 1'b1;
    wait_load(lat);
    chk("load_addr", int'(dp_if.wr_addr), exp_addr);
    cyc(1);
    ready = 1'b1;
    cyc(1);
    ready = 1'b0;
    chk("load_drop", int'(dp_if.loaddata), 0);
    spent = lat + 2;
    if (last) begin
      chk("calc_start_on", int'(dp_if.calc_start), 1);
      done = inject;
      cyc(1);
      done = 1'b0;
      spent++;
      chk("calc_start_once", int'(dp_if.calc_start), 0);
      chk("no_show_in_calc", int'(show), 0);
    end
    while (spent < hold) begin
      @(negedge clk);
      spent++;
    end
    enter = 1'b0;
    cyc(4);
  endtask

  task automatic press_pulse();
    enter = 1'b1;
    cyc(8);
    enter = 1'b0;
    cyc(4);
  endtask

  task automatic finish_calc(input int exp_fc);
    cyc(2);
    done = 1'b1;
    cyc(1);
    done = 1'b0;
    chk("show_after_done", int'(show), 1);
    chk("frame_cnt", int'(frame_cnt), exp_fc);
  endtask

  task automatic bytes(input int from, input int upto, input bit inject);
    int lat;
    for (int a = from; a <= upto; a++)
      load_byte(a, 12, a == DEPTH - 1, inject, lat);
  endtask

  initial begin
    int lat, r0;
    cyc(2);
    reset = 1'b0;
    chk("rst_loaddata", int'(dp_if.loaddata), 0);
    chk("rst_wr_addr", int'(dp_if.wr_addr), 0);
    chk("rst_calc_start", int'(dp_if.calc_start), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_show", int'(show), 0);
    chk("rst_frame_cnt", int'(frame_cnt), 0);
    chk("rst_err", int'(err), 0);

    load_byte(0, 10, 1'b0, 1'b0, lat);
    chk("press_latency", lat, 7);
    chk("addr_after_first", int'(dp_if.wr_addr), 1);

    r0 = ld_rise;
    enter = 1'b1;
    cyc(3);
    enter = 1'b0;
    cyc(12);
    chk("short_press_loads", ld_rise - r0, 0);
    chk("short_press_addr", int'(dp_if.wr_addr), 1);

    r0 = ld_rise;
    load_byte(1, 50, 1'b0, 1'b0, lat);
    chk("long_hold_loads", ld_rise - r0, 1);
    chk("long_hold_addr", int'(dp_if.wr_addr), 2);

    bytes(2, DEPTH - 1, 1'b1);
    chk("busy_wait_done", int'(busy), 1);
    finish_calc(1);

    ready = 1'b1;
    cyc(1);
    ready = 1'b0;
    cyc(1);
    chk("ready_in_show", int'(show), 1);
    chk("addr_in_show", int'(dp_if.wr_addr), DEPTH - 1);
    r0 = ld_rise;
    enter = 1'b1;
    cyc(10);
    enter = 1'b0;
    cyc(4);
    chk("show_press_busy", int'(busy), 0);
    chk("show_press_show", int'(show), 0);
    chk("show_press_addr", int'(dp_if.wr_addr), 0);
    chk("show_press_noload", ld_rise - r0, 0);
    ready = 1'b1;
    cyc(1);
    ready = 1'b0;
    cyc(2);
    chk("ready_in_idle", int'(busy), 0);

    enter = 1'b1;
    wait_load(lat);
    enter = 1'b0;
    cyc(4);
    enter = 1'b1;
    cyc(8);
    enter = 1'b0;
    cyc(4);
    chk("press_in_load_ld", int'(dp_if.loaddata), 1);
    chk("press_in_load_addr", int'(dp_if.wr_addr), 0);
    ready = 1'b1;
    cyc(1);
    ready = 1'b0;
    cyc(6);
    chk("press_not_queued", int'(dp_if.loaddata), 0);
    chk("addr_after_discard", int'(dp_if.wr_addr), 1);
    bytes(1, DEPTH - 1, 1'b0);
    finish_calc(2);

    for (int f = 3; f <= 16; f++) begin
      press_pulse();
      bytes(0, DEPTH - 1, 1'b0);
      finish_calc(f % 16);
    end

    press_pulse();
    bytes(0, 4, 1'b0);
    enter = 1'b1;
    wait_load(lat);
    chk("pre_reset_addr", int'(dp_if.wr_addr), 5);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    enter = 1'b0;
    chk("reset_in_load_ld", int'(dp_if.loaddata), 0);
    chk("reset_in_load_addr", int'(dp_if.wr_addr), 0);
    chk("reset_in_load_fc", int'(frame_cnt), 0);
    cyc(4);

    enter = 1'b1;
    wait_load(lat);
`ifdef SEQ_TIMEOUT_EN
    cyc(14);
    chk("timeout_not_yet", int'(err), 0);
    cyc(1);
    chk("timeout_err", int'(err), 1);
    chk("timeout_ld", int'(dp_if.loaddata), 0);
    chk("timeout_busy", int'(busy), 1);
    enter = 1'b0;
    ready = 1'b1;
    cyc(1);
    ready = 1'b0;
    cyc(5);
    chk("err_sticky", int'(err), 1);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk("err_cleared", int'(err), 0);
`else
    cyc(100);
    chk("load_persists", int'(dp_if.loaddata), 1);
    chk("no_err", int'(err), 0);
    enter = 1'b0;
    ready = 1'b1;
    cyc(1);
    ready = 1'b0;
`endif
    cyc(4);

    begin
      int left = 0;
      for (int i = 0; i < 4000; i++) begin
        if (left > 0) left--;
        else if (enter) begin enter = 1'b0; left = $urandom_range(1, 6); end
        else begin enter = 1'b1; left = $urandom_range(1, 12); end
        ready = dp_if.loaddata ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
        done  = ($urandom_range(0, 4) == 0);
        reset = ($urandom_range(0, 599) == 0);
        cyc(1);
      end
      reset = 1'b0;
      enter = 1'b0;
      ready = 1'b0;
      done  = 1'b0;
      cyc(2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
